// File: rtl/option_pkg.sv
// Shared constants and FSM state type for the option payoff datapath.
package option_pkg;

  localparam int unsigned PRICE_W = 12;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/payoff_calc.sv
// Call payoff max(P-K, 0) on unsigned prices; purely combinational.
module payoff_calc
  import option_pkg::*;
(
  input  logic [PRICE_W-1:0] price_i,
  input  logic [PRICE_W-1:0] strike_i,
  output logic [PRICE_W-1:0] payoff_o
);

  assign payoff_o = (price_i > strike_i) ? (price_i - strike_i) : '0;

endmodule

// File: rtl/payoff_accum.sv
// Accumulates per-path call payoffs over 2^PATHS_LOG2 paths of 2^DAYS_LOG2 samples.
// Define ASIAN_PAYOFF_EN to price on the path average instead of the last-day sample.
module payoff_accum
  import option_pkg::*;
#(
  parameter int unsigned DAYS_LOG2  = 3,
  parameter int unsigned PATHS_LOG2 = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [PRICE_W-1:0]            strike_i,
  input  logic                          in_valid_i,
  input  logic [PRICE_W-1:0]            in_path_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [PRICE_W+PATHS_LOG2-1:0] payoff_sum_o,
  output logic [PRICE_W-1:0]            payoff_mean_o
);

  // Counters keep at least one bit so a single-day or single-path build still elaborates.
  localparam int unsigned DayW  = (DAYS_LOG2 > 0) ? DAYS_LOG2 : 1;
  localparam int unsigned PathW = (PATHS_LOG2 > 0) ? PATHS_LOG2 : 1;
  localparam int unsigned SumW  = PRICE_W + PATHS_LOG2;

  localparam logic [DayW-1:0]  LastDay  = DayW'((1 << DAYS_LOG2) - 1);
  localparam logic [PathW-1:0] LastPath = PathW'((1 << PATHS_LOG2) - 1);

  state_e               state_q;
  logic                 busy_q, done_q;
  logic [PRICE_W-1:0]   strike_q;
  logic [DayW-1:0]      day_q;
  logic [PathW-1:0]     path_q;
  logic [SumW-1:0]      acc_q, sum_q;
  logic [PRICE_W-1:0]   mean_q;

  logic                 accept, last_day, last_path;
  logic [PRICE_W-1:0]   price, payoff;
  logic [SumW-1:0]      acc_next;
  logic [PRICE_W-1:0]   mean_next;

  assign accept    = (state_q == StRun) && in_valid_i;
  assign last_day  = (day_q == LastDay);
  assign last_path = (path_q == LastPath);

`ifdef ASIAN_PAYOFF_EN
  localparam int unsigned AvgW = PRICE_W + DAYS_LOG2;

  logic [AvgW-1:0] day_sum_q, day_sum_next;

  // The current sample is folded in before averaging so the last day counts.
  assign day_sum_next = day_sum_q + AvgW'(in_path_i);
  assign price        = PRICE_W'(day_sum_next >> DAYS_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_sum_q <= '0;
    end else if ((state_q == StIdle) && start_i) begin
      day_sum_q <= '0;
    end else if (accept) begin
      day_sum_q <= last_day ? '0 : day_sum_next;
    end
  end
`else
  assign price = in_path_i;
`endif

  payoff_calc u_payoff_calc (
    .price_i  (price),
    .strike_i (strike_q),
    .payoff_o (payoff)
  );

  assign acc_next  = acc_q + SumW'(payoff);
  assign mean_next = PRICE_W'(acc_next >> PATHS_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strike_q <= '0;
      day_q    <= '0;
      path_q   <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      mean_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q  <= StRun;
            busy_q   <= 1'b1;
            strike_q <= strike_i;
            day_q    <= '0;
            path_q   <= '0;
            acc_q    <= '0;
          end
        end
        StRun: begin
          if (in_valid_i) begin
            day_q <= last_day ? '0 : day_q + 1'b1;
            if (last_day) begin
              acc_q  <= acc_next;
              path_q <= last_path ? '0 : path_q + 1'b1;
              // Results are registered here so they appear together with done.
              if (last_path) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                sum_q   <= acc_next;
                mean_q  <= mean_next;
              end
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign payoff_sum_o  = sum_q;
  assign payoff_mean_o = mean_q;

endmodule

// File: tb/tb_payoff_accum.sv
// Randomised and directed bench for payoff_accum (4 days x 4 paths), reference model inside.
module tb_payoff_accum;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [11:0] strike_i;
  logic        in_valid_i;
  logic [11:0] in_path_i;
  logic        busy_o;
  logic        done_o;
  logic [13:0] payoff_sum_o;
  logic [11:0] payoff_mean_o;

  int n_assert;
  int n_fail;

  logic [11:0] samp [16];

  payoff_accum #(
    .DAYS_LOG2  (2),
    .PATHS_LOG2 (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .strike_i      (strike_i),
    .in_valid_i    (in_valid_i),
    .in_path_i     (in_path_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .payoff_sum_o  (payoff_sum_o),
    .payoff_mean_o (payoff_mean_o)
  );

`ifdef ASIAN_PAYOFF_EN
  logic        a_start, a_valid, a_busy, a_done;
  logic [11:0] a_strike, a_path, a_sum, a_mean;

  payoff_accum #(
    .DAYS_LOG2  (2),
    .PATHS_LOG2 (0)
  ) dut_asian (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (a_start),
    .strike_i      (a_strike),
    .in_valid_i    (a_valid),
    .in_path_i     (a_path),
    .busy_o        (a_busy),
    .done_o        (a_done),
    .payoff_sum_o  (a_sum),
    .payoff_mean_o (a_mean)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: per-path price is last-day sample, or the truncated mean of the path's days.
  function automatic int model_sum(input int k);
    int sum;
    sum = 0;
    for (int p = 0; p < 4; p++) begin
      int s, price;
      s = 0;
      for (int d = 0; d < 4; d++) s += int'(samp[p*4+d]);
`ifdef ASIAN_PAYOFF_EN
      price = s / 4;
`else
      price = int'(samp[p*4+3]);
`endif
      if (price > k) sum += price - k;
    end
    return sum;
  endfunction

  task automatic fill(input bit directed);
    for (int i = 0; i < 16; i++) samp[i] = 12'($urandom_range(0, 4095));
    if (directed) begin
      samp[3]  = 12'd150;
      samp[7]  = 12'd80;
      samp[11] = 12'd100;
      samp[15] = 12'd120;
    end
  endtask

  // One full run: inputs change on negedge, outputs are sampled on negedge.
  task automatic run(input logic [11:0] k, input bit gaps, input bit noise);
    int exp_sum;
    exp_sum = model_sum(int'(k));
    if (noise) begin
      repeat (3) begin
        @(negedge clk);
        in_valid_i = 1'b1;
        in_path_i  = 12'($urandom);
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0;
    start_i    = 1'b1;
    strike_i   = k;
    @(negedge clk);
    start_i  = 1'b0;
    strike_i = 12'($urandom);
    chk("busy_in_run", 32'(busy_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid_i = 1'b0;
          in_path_i  = 12'($urandom);
          @(negedge clk);
          chk("no_done_in_gap", 32'(done_o), 32'd0);
        end
      end
      in_valid_i = 1'b1;
      in_path_i  = samp[i];
      if (noise && i == 5) begin
        start_i  = 1'b1;
        strike_i = ~k;
      end
      @(negedge clk);
      start_i    = 1'b0;
      in_valid_i = 1'b0;
      if (i < 15) begin
        chk("no_early_done", 32'(done_o), 32'd0);
      end else begin
        chk("done_latency", 32'(done_o), 32'd1);
        chk("sum", 32'(payoff_sum_o), 32'(exp_sum));
        chk("mean", 32'(payoff_mean_o), 32'(exp_sum / 4));
      end
    end
    if (noise) begin
      in_valid_i = 1'b1;
      in_path_i  = 12'($urandom);
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done_o), 32'd0);
    chk("busy_after", 32'(busy_o), 32'd0);
    in_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("sum_hold", 32'(payoff_sum_o), 32'(exp_sum));
    chk("mean_hold", 32'(payoff_mean_o), 32'(exp_sum / 4));
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    strike_i   = '0;
    in_valid_i = 1'b0;
    in_path_i  = '0;
`ifdef ASIAN_PAYOFF_EN
    a_start  = 1'b0;
    a_strike = '0;
    a_valid  = 1'b0;
    a_path   = '0;
`endif
    #2;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_sum", 32'(payoff_sum_o), 32'd0);
    chk("rst_mean", 32'(payoff_mean_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed strike 100, final-day prices 150/80/100/120.
    fill(1'b1);
    run(12'd100, 1'b0, 1'b0);
    run(12'd100, 1'b1, 1'b0);
    run(12'd100, 1'b0, 1'b1);

    // Abort after 7 samples, then a clean rerun.
    @(negedge clk);
    start_i  = 1'b1;
    strike_i = 12'd100;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid_i = 1'b1;
      in_path_i  = samp[i];
      @(negedge clk);
      chk("abort_no_done", 32'(done_o), 32'd0);
    end
    in_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_sum", 32'(payoff_sum_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(12'd100, 1'b0, 1'b0);

    // Random strikes and prices, including strike equal to a price.
    for (int r = 0; r < 6; r++) begin
      logic [11:0] k;
      fill(1'b0);
      k = 12'($urandom_range(0, 4095));
      if (r == 2) samp[3] = k;
      run(k, r[0], r[1]);
    end

`ifdef ASIAN_PAYOFF_EN
    begin
      logic [11:0] days [4];
      days[0] = 12'd100;
      days[1] = 12'd110;
      days[2] = 12'd120;
      days[3] = 12'd130;
      @(negedge clk);
      a_start  = 1'b1;
      a_strike = 12'd100;
      @(negedge clk);
      a_start = 1'b0;
      for (int d = 0; d < 4; d++) begin
        a_valid = 1'b1;
        a_path  = days[d];
        @(negedge clk);
      end
      a_valid = 1'b0;
      chk("asian_done", 32'(a_done), 32'd1);
      chk("asian_sum", 32'(a_sum), 32'd15);
      chk("asian_mean", 32'(a_mean), 32'd15);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/payoff_accum.md
PAYOFF_ACCUM -- requirements
Module: payoff_accum

Interface
REQ-001 Parameter DAYS_LOG2, default 3, log2 of the number of daily price samples per path.
REQ-002 Parameter PATHS_LOG2, default 10, log2 of the number of paths per run.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle run request; honoured only in IDLE.
REQ-006 strike  input  12  unsigned integer strike K; sampled on an accepted start.
REQ-007 in_valid  input  1  path sample qualifier from the path generator; no backpressure.
REQ-008 in_path  input  12  unsigned integer price sample S; valid when in_valid=1.
REQ-009 busy  output  1  high in RUN.
REQ-010 done  output  1  one-cycle pulse marking run completion.
REQ-011 payoff_sum  output  12+PATHS_LOG2  sum of per-path payoffs for the last completed run.
REQ-012 payoff_mean  output  12  payoff_sum >> PATHS_LOG2 (truncating).

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE -> RUN on start=1; the same cycle latches strike and clears the day counter, path counter, internal accumulator, and (if configured) the day sum.
REQ-015 In RUN, each cycle with in_valid=1 accepts one sample and increments the day counter modulo 2^DAYS_LOG2.
REQ-016 When the day counter equals 2^DAYS_LOG2-1 on an accepted sample, the block computes payoff = (P > K) ? P-K : 0, adds it to the accumulator, and increments the path counter; P is defined by REQ-028/029.
REQ-017 On the accepted sample with last day and last path (path counter = 2^PATHS_LOG2-1), the block transitions RUN -> DONE.
REQ-018 In DONE, done=1 for exactly one cycle, payoff_sum and payoff_mean update from the accumulator, and the next state is IDLE.
REQ-019 done asserts in the cycle immediately after the final sample is accepted; latency is 1 cycle.
REQ-020 Cycles with in_valid=0 in RUN leave all state unchanged; gaps of any length are allowed.
REQ-021 in_valid in IDLE or DONE is ignored.
REQ-022 start in RUN or DONE is ignored.
REQ-023 payoff_sum and payoff_mean hold their values until the next DONE.
REQ-024 The accumulator width is 12+PATHS_LOG2 bits, so no overflow is possible; payoff arithmetic is unsigned.
REQ-025 P = K yields a payoff of 0.

Reset
REQ-026 When rst_n=0, the state is IDLE; busy, done, payoff_sum, payoff_mean, all counters, and the latched strike are 0, immediately and asynchronously.
REQ-027 Reset during RUN abandons the run without asserting done; the next start begins a clean run.

Configuration
REQ-028 With ASIAN_PAYOFF_EN defined: the block keeps a per-path day sum of width 12+DAYS_LOG2, sets P = day_sum >> DAYS_LOG2 (arithmetic average of the path), and clears the day sum after each path.
REQ-029 Without ASIAN_PAYOFF_EN: P = the last-day sample (European payoff), and no day-sum register exists.

Structure
REQ-030 The shared package option_pkg holds the constant PRICE_W=12 and the FSM state typedef.
REQ-031 The combinational sub-module payoff_calc computes max(P-K,0) from P and K.

Verification
REQ-032 Reset check: assert rst_n=0 -> busy=0, done=0, payoff_sum=0, payoff_mean=0.
REQ-033 DAYS_LOG2=2, PATHS_LOG2=2, K=100, final-day prices 150, 80, 100, 120, 16 back-to-back samples -> payoffs 50, 0, 0, 20; payoff_sum=70; payoff_mean=17; done pulses 1 cycle after the 16th sample.
REQ-034 Same stimulus as REQ-033 with random in_valid gaps -> identical sum and mean, and done 1 cycle after the last valid sample.
REQ-035 Pulse start mid-RUN and drive in_valid while in IDLE -> no effect on the results of REQ-033.
REQ-036 Reset after 7 samples, then rerun REQ-033 -> no done during the aborted run; the rerun gives payoff_sum=70.
REQ-037 With ASIAN_PAYOFF_EN defined, 1 path with days 100, 110, 120, 130, K=100, PATHS_LOG2=0 -> P=115, payoff_sum=15.
